// File: rtl/power_stream_sequencer.sv
// Frame-level pacing controller for the hotspot power delay line: fills, streams and
// flushes an external DEPTH-shift delay buffer once per stencil iteration.
module power_stream_sequencer #(
   parameter int DATA_WIDTH = 32,
   parameter int COLS       = 512,
   parameter int ROWS       = 512,
   parameter int DEPTH      = 512,
   parameter int ITER_WIDTH = 16
) (
   input  logic                  aclk,
   input  logic                  axi_reset,
   input  logic                  start,
   input  logic [ITER_WIDTH-1:0] iterations,
   output logic                  busy,
   output logic                  done,
   output logic [ITER_WIDTH-1:0] iter_count,
   input  logic [DATA_WIDTH-1:0] s_axis_power_data,
   input  logic                  s_axis_power_valid,
   output logic                  s_axis_power_ready,
   output logic [DATA_WIDTH-1:0] buf_in_data,
   output logic                  buf_in_valid,
   output logic                  buf_shift_ready,
   input  logic [DATA_WIDTH-1:0] buf_out_data,
   output logic [DATA_WIDTH-1:0] m_axis_power_data,
   output logic                  m_axis_power_valid,
   input  logic                  m_axis_power_ready,
   output logic                  m_axis_power_last
);

   localparam int N  = ROWS * COLS;
   localparam int CW = $clog2(N + DEPTH + 1);

   localparam logic [CW-1:0] C_N     = CW'(N);
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] C_END   = CW'(N + DEPTH);
   localparam logic [CW-1:0] C_LASTK = CW'(N - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_RUN,
      S_FLUSH,
      S_DRAIN
   } state_t;

   state_t                r_state;
   logic [CW-1:0]         r_in_cnt;
   logic [CW-1:0]         r_shift_cnt;
   logic [CW-1:0]         r_out_cnt;
   logic [ITER_WIDTH-1:0] r_iterations;
   logic [ITER_WIDTH-1:0] r_iter_count;
   logic                  r_pend;
   logic                  r_busy;
   logic                  r_done;

   logic                  w_in_phase;
   logic                  w_can_shift;
   logic                  w_up_hs;
   logic                  w_flush_shift;
   logic                  w_shift;
   logic                  w_out_hs;
   logic                  w_last_out;
   logic [CW-1:0]         w_shift_nxt;
   logic [CW-1:0]         w_in_nxt;
   logic [ITER_WIDTH-1:0] w_iter_nxt;

   // The buffer only shifts when the tail slot is free or being consumed, so the
   // tail presented downstream never changes under backpressure.
   always_comb begin
      // NOTE: every signal gets a value before any branch, so no latch can be inferred.
      w_in_phase    = (r_state == S_FILL) || (r_state == S_RUN);
      w_can_shift   = !r_pend || m_axis_power_ready;
      w_up_hs       = w_in_phase && w_can_shift && s_axis_power_valid;
      w_flush_shift = (r_state == S_FLUSH) && w_can_shift;
      w_shift       = w_up_hs || w_flush_shift;
      w_out_hs      = r_pend && m_axis_power_ready;
      w_last_out    = (r_out_cnt == C_LASTK);
      w_shift_nxt   = r_shift_cnt + 1'b1;
      w_in_nxt      = r_in_cnt + 1'b1;
      w_iter_nxt    = r_iter_count + 1'b1;
   end

   assign s_axis_power_ready = w_in_phase && w_can_shift;
   assign buf_in_valid       = w_shift;
   assign buf_shift_ready    = w_shift;
   assign buf_in_data        = w_in_phase ? s_axis_power_data : '0;
   assign m_axis_power_valid = r_pend;
   assign m_axis_power_data  = r_pend ? buf_out_data : '0;
   assign m_axis_power_last  = r_pend && w_last_out;
   assign busy               = r_busy;
   assign done               = r_done;
   assign iter_count         = r_iter_count;

   always_ff @(posedge aclk) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees
      // pre-edge values; later assignments in this block deliberately override earlier ones.
      if (axi_reset) begin
         r_state      <= S_IDLE;
         r_in_cnt     <= '0;
         r_shift_cnt  <= '0;
         r_out_cnt    <= '0;
         r_iterations <= '0;
         r_iter_count <= '0;
         r_pend       <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done <= 1'b0;

         if (r_state != S_IDLE) begin
            if (w_shift)  r_shift_cnt <= w_shift_nxt;
            if (w_up_hs)  r_in_cnt    <= w_in_nxt;
            if (w_out_hs) r_out_cnt   <= r_out_cnt + 1'b1;
            // Shifts past the fill depth push a live sample out of the tail.
            if (w_shift && (r_shift_cnt >= C_DEPTH)) r_pend <= 1'b1;
            else if (w_out_hs)                       r_pend <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (iterations != '0) begin
                     r_state      <= S_FILL;
                     r_busy       <= 1'b1;
                     r_iterations <= iterations;
                     r_iter_count <= '0;
                     r_in_cnt     <= '0;
                     r_shift_cnt  <= '0;
                     r_out_cnt    <= '0;
                     r_pend       <= 1'b0;
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            S_FILL: begin
               if (w_shift && (w_shift_nxt == C_DEPTH))
                  r_state <= (w_in_nxt == C_N) ? S_FLUSH : S_RUN;
            end
            S_RUN: begin
               if (w_up_hs && (w_in_nxt == C_N)) r_state <= S_FLUSH;
            end
            S_FLUSH: begin
               if (w_flush_shift && (w_shift_nxt == C_END)) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (w_out_hs && w_last_out) begin
                  r_in_cnt    <= '0;
                  r_shift_cnt <= '0;
                  r_out_cnt   <= '0;
                  if (w_iter_nxt < r_iterations) begin
                     r_state      <= S_FILL;
                     r_iter_count <= w_iter_nxt;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_power_stream_sequencer.sv
// Bench for power_stream_sequencer with a behavioural delay buffer and an in-order
// scoreboard (outputs equal accepted inputs, last on every N-th output).
module tb_power_stream_sequencer;

   localparam int DW    = 32;
   localparam int COLS  = 4;
   localparam int ROWS  = 2;
   localparam int DEPTH = 4;
   localparam int IW    = 16;
   localparam int N     = COLS * ROWS;

   logic          aclk;
   logic          axi_reset;
   logic          start;
   logic [IW-1:0] iterations;
   logic          busy;
   logic          done;
   logic [IW-1:0] iter_count;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] buf_in_data;
   logic          buf_in_valid;
   logic          buf_shift_ready;
   logic [DW-1:0] buf_out_data;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          m_last;

   power_stream_sequencer #(
      .DATA_WIDTH(DW), .COLS(COLS), .ROWS(ROWS), .DEPTH(DEPTH), .ITER_WIDTH(IW)
   ) dut (
      .aclk               (aclk),
      .axi_reset          (axi_reset),
      .start              (start),
      .iterations         (iterations),
      .busy               (busy),
      .done               (done),
      .iter_count         (iter_count),
      .s_axis_power_data  (s_data),
      .s_axis_power_valid (s_valid),
      .s_axis_power_ready (s_ready),
      .buf_in_data        (buf_in_data),
      .buf_in_valid       (buf_in_valid),
      .buf_shift_ready    (buf_shift_ready),
      .buf_out_data       (buf_out_data),
      .m_axis_power_data  (m_data),
      .m_axis_power_valid (m_valid),
      .m_axis_power_ready (m_ready),
      .m_axis_power_last  (m_last)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // Delay buffer: each shift presents the sample pushed DEPTH shifts earlier.
   logic [DW-1:0] bmem [DEPTH];
   logic [DW-1:0] btail;
   assign buf_out_data = btail;
   initial begin
      btail = '0;
      for (int i = 0; i < DEPTH; i++) bmem[i] = '0;
   end
   always @(posedge aclk) begin
      if (buf_in_valid && buf_shift_ready) begin
         btail <= bmem[DEPTH-1];
         for (int i = DEPTH - 1; i > 0; i--) bmem[i] <= bmem[i-1];
         bmem[0] <= buf_in_data;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h @%0t", name, got, exp, $time);
      end
   endtask

   // Scoreboard and logs, owned by the compare process.
   logic [DW-1:0] in_q [$];
   int            cyc = 0, out_k = 0, out_n = 0, acc_total = 0, rise_n = 0;
   int            flush_n = 0, done_n = 0, last_cyc = 0, done_cyc = 0;
   logic          done_busy = 1'b0;
   logic [DW-1:0] out_log  [256];
   logic          last_log [256];
   logic [IW-1:0] iter_log [256];
   int            out_cyc  [256];
   int            rise_acc [64];
   logic          prev_valid = 1'b0, prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;

   initial begin
      forever begin
         @(negedge aclk);
         cyc++;
         if (axi_reset) begin
            in_q.delete();
            out_k      = 0;
            prev_valid = 1'b0;
            prev_stall = 1'b0;
         end else begin
            check("shift_ready_eq_valid", buf_shift_ready, buf_in_valid);
            if (m_last) check("last_without_valid", m_valid, 1'b1);
            if (prev_stall) begin
               check("hold_valid", m_valid, 1'b1);
               check("hold_data", m_data, prev_data);
            end
            if (m_valid && !m_ready) begin
               check("stall_s_ready", s_ready, 1'b0);
               check("stall_shift", buf_in_valid, 1'b0);
            end
            if (m_valid && !prev_valid && rise_n < 64) begin
               rise_acc[rise_n] = acc_total;
               rise_n++;
            end
            if (m_valid && m_ready) begin
               if (in_q.size() == 0) check("out_underflow", 1'b1, 1'b0);
               else begin
                  check("sb_data", m_data, in_q.pop_front());
                  check("sb_last", m_last, (out_k % N) == N - 1);
               end
               if (out_n < 256) begin
                  out_log[out_n]  = m_data;
                  last_log[out_n] = m_last;
                  iter_log[out_n] = iter_count;
                  out_cyc[out_n]  = cyc;
                  out_n++;
               end
               out_k++;
               if (m_last) last_cyc = cyc;
            end
            if (s_valid && s_ready) begin
               in_q.push_back(s_data);
               acc_total++;
            end
            if (buf_in_valid && !s_ready) begin
               flush_n++;
               check("flush_zero", buf_in_data, '0);
            end
            if (done) begin
               done_n++;
               done_cyc  = cyc;
               done_busy = busy;
            end
            prev_valid = m_valid;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
         end
      end
   end

   // Stimulus: inputs change 1 after the rising edge, observations at the falling edge.
   int            src_idx = 0;
   logic          src_en = 1'b0, hs_in = 1'b0, rand_mode = 1'b0, nx_clr = 1'b0;
   logic          nx_reset = 1'b1, nx_start = 1'b0, nx_ready = 1'b0;
   logic [IW-1:0] nx_iter = '0;

   task automatic tick();
      @(posedge aclk);
      #1;
      if (nx_clr) src_idx = 0;
      else if (hs_in) src_idx++;
      nx_clr     = 1'b0;
      axi_reset  = nx_reset;
      start      = nx_start;
      iterations = nx_iter;
      if (rand_mode) begin
         s_valid    = 1'($urandom_range(0, 1));
         s_data     = $urandom;
         m_ready    = 1'($urandom_range(0, 1));
         start      = 1'($urandom_range(0, 1));
         iterations = IW'($urandom);
      end else begin
         s_valid = src_en;
         s_data  = DW'(src_idx % N + 1);
         m_ready = nx_ready;
      end
      @(negedge aclk);
      hs_in = s_valid && s_ready;
   endtask

   task automatic pulse_start(input logic [IW-1:0] it);
      nx_iter  = it;
      nx_start = 1'b1;
      tick();
      nx_start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      logic got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         tick();
         if (done) got = 1'b1;
      end
      check({name, "_done_timeout"}, got, 1'b1);
      tick();
   endtask

   task automatic check_idle(input string name);
      check({name, "_ctl"}, {busy, done, s_ready, buf_in_valid, buf_shift_ready, m_valid, m_last}, '0);
      check({name, "_iter"}, iter_count, '0);
      check({name, "_bdata"}, buf_in_data, '0);
      check({name, "_mdata"}, m_data, '0);
   endtask

   // Hand-computed expectations: k-th output of a pass is k%N+1, last on k%N==N-1.
   task automatic check_seq(input string name, input int base, input int cnt, input int exp_n);
      check({name, "_count"}, out_n - base, exp_n);
      for (int k = 0; k < cnt; k++) begin
         check({name, "_data"}, out_log[base+k], k % N + 1);
         check({name, "_last"}, last_log[base+k], (k % N) == N - 1);
         check({name, "_iter"}, iter_log[base+k], k / N);
      end
   endtask

   initial begin
      int ob, ab, rb, fb, db, seen;
      logic ok;
      axi_reset = 1'b1; start = 1'b0; iterations = '0;
      s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

      // Reset with random inputs.
      rand_mode = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_idle("reset");
      end
      rand_mode = 1'b0; nx_reset = 1'b0; nx_ready = 1'b1; src_en = 1'b1; nx_clr = 1'b1;
      tick(); tick();

      // Single iteration, continuous flow.
      ob = out_n; ab = acc_total; rb = rise_n; fb = flush_n; db = done_n;
      pulse_start(16'd1);
      check("busy_before_edge", busy, 1'b0);
      tick();
      check("busy_rise", busy, 1'b1);
      wait_done("single");
      check_seq("single", ob, N, N);
      check("first_valid_after_5th", rise_acc[rb] - ab, 5);
      check("throughput", out_cyc[ob+N-1] - out_cyc[ob], N - 1);
      check("done_latency", done_cyc - last_cyc, 1);
      check("busy_fall_with_done", done_busy, 1'b0);
      check("flush_shifts", flush_n - fb, DEPTH);
      check("single_done_cnt", done_n - db, 1);
      check("sb_empty", in_q.size(), 0);

      // Backpressure while pend=1.
      nx_clr = 1'b1; tick();
      ob = out_n; fb = flush_n;
      pulse_start(16'd1);
      seen = 0;
      for (int i = 0; i < 100 && seen < 2; i++) begin
         tick();
         if (m_valid && m_ready) seen++;
      end
      check("bp_reach_timeout", seen, 2);
      nx_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_valid", m_valid, 1'b1);
         check("bp_tail", m_data, 32'd3);
         check("bp_s_ready", s_ready, 1'b0);
         check("bp_shift", buf_in_valid, 1'b0);
      end
      nx_ready = 1'b1;
      wait_done("bp");
      check_seq("bp", ob, N, N);
      check("bp_flush", flush_n - fb, DEPTH);

      // Three iterations.
      nx_clr = 1'b1; tick();
      ob = out_n; fb = flush_n; db = done_n;
      pulse_start(16'd3);
      wait_done("iter3");
      for (int i = 0; i < 5; i++) tick();
      check_seq("iter3", ob, 3 * N, 3 * N);
      check("iter3_done_cnt", done_n - db, 1);
      check("iter3_flush", flush_n - fb, 3 * DEPTH);

      // Zero iterations.
      nx_clr = 1'b1; tick();
      ob = out_n;
      pulse_start(16'd0);
      check("zero_s_ready_a", s_ready, 1'b0);
      tick();
      check("zero_done", done, 1'b1);
      check("zero_busy", busy, 1'b0);
      check("zero_s_ready_b", s_ready, 1'b0);
      tick();
      check("zero_done_drop", done, 1'b0);
      check("zero_s_ready_c", s_ready, 1'b0);
      check("zero_no_out", out_n - ob, 0);

      // Start while busy is ignored.
      db = done_n;
      pulse_start(16'd1);
      for (int i = 0; i < 3; i++) tick();
      check("ign_busy", busy, 1'b1);
      pulse_start(16'd2);
      wait_done("ign");
      for (int i = 0; i < 20; i++) tick();
      check_seq("ign", ob, N, N);
      check("ign_done_cnt", done_n - db, 1);
      check("ign_idle", busy, 1'b0);

      // Reset in the middle of RUN.
      nx_clr = 1'b1; tick();
      ob = out_n;
      pulse_start(16'd1);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         tick();
         if (src_idx == 6) ok = 1'b1;
      end
      check("mid_reach_timeout", ok, 1'b1);
      nx_reset = 1'b1;
      tick();
      nx_reset = 1'b0;
      tick();
      check_idle("mid_reset");
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done || busy) ok = 1'b0;
      end
      check("mid_no_done", ok, 1'b1);
      nx_clr = 1'b1; tick();
      ob = out_n;
      pulse_start(16'd1);
      wait_done("fresh");
      check_seq("fresh", ob, N, N);
      check("fresh_sb_empty", in_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/power_stream_sequencer.md
# power_stream_sequencer

Frame-level controller for the hotspot power delay line. It sits between the power DMA stream and the power delay buffer, and paces every shift of that buffer. It runs one or more stencil iterations per start command. For each iteration it:
- pre-fills the buffer, with output suppressed;
- streams aligned power samples to the stencil core;
- flushes the tail by injecting zeros, marking the final sample with `last`.

## Interface
Parameters:
- DATA_WIDTH, 32, power sample width (Q1.31)
- COLS, 512, grid columns
- ROWS, 512, grid rows
- DEPTH, 512, delay-buffer SIZE (tail = sample pushed DEPTH shifts earlier); must equal the buffer's SIZE
- ITER_WIDTH, 16, iteration counter width

Ports:
- aclk  in  1  clock; all logic on rising edge
- axi_reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle command pulse; ignored while busy
- iterations  in  ITER_WIDTH  iteration count, latched on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of command
- iter_count  out  ITER_WIDTH  index of current iteration (0-based)
- s_axis_power_data  in  DATA_WIDTH  power sample from DMA
- s_axis_power_valid  in  1  upstream valid
- s_axis_power_ready  out  1  upstream ready
- buf_in_data  out  DATA_WIDTH  sample pushed into delay buffer
- buf_in_valid  out  1  shift strobe to buffer
- buf_shift_ready  out  1  drives the buffer's downstream ready; equal to buf_in_valid
- buf_out_data  in  DATA_WIDTH  buffer tail
- m_axis_power_data  out  DATA_WIDTH  aligned sample to stencil core (= buf_out_data)
- m_axis_power_valid  out  1  output valid
- m_axis_power_ready  in  1  downstream ready
- m_axis_power_last  out  1  final sample of the iteration

## Operation
- N = ROWS*COLS samples per iteration.
- Counters:
  - in_cnt: accepted inputs, 0..N.
  - shift_cnt: shifts this iteration, 0..N+DEPTH.
  - out_cnt: outputs this iteration, 0..N.
- Counter widths: clog2(N+DEPTH+1); iter_count is ITER_WIDTH.
- States:
  - IDLE: waits for start.
  - FILL: shift_cnt < DEPTH.
  - RUN: in_cnt < N, shift_cnt ≥ DEPTH.
  - FLUSH: in_cnt == N, shift_cnt < N+DEPTH.
  - DRAIN: last output pending.
- pend: single-bit register meaning "tail holds an unconsumed valid sample". m_axis_power_valid = pend.
- can_shift = !pend | m_axis_power_ready.
- In FILL and RUN:
  - s_axis_power_ready = can_shift.
  - A shift happens on upstream handshake; buf_in_data = s_axis_power_data.
- In FLUSH:
  - buf_in_valid = can_shift; buf_in_data = 0.
  - s_axis_power_ready = 0.
- On each shift with pre-increment shift_cnt ≥ DEPTH, pend is set next cycle. Otherwise pend clears on output handshake.
- The buffer never shifts while pend & !ready. The tail therefore stays stable under backpressure.
- Output k (0..N-1) is the k-th input sample. m_axis_power_last = pend & (out_cnt == N-1).
- Transitions:
  - IDLE→FILL on start with iterations ≠ 0. Counters cleared, iterations latched, iter_count=0.
  - FILL→RUN when shift_cnt reaches DEPTH.
  - RUN→FLUSH when in_cnt reaches N.
  - FLUSH→DRAIN when shift_cnt reaches N+DEPTH.
  - DRAIN→FILL on the last handshake if more iterations remain. iter_count increments and per-iteration counters clear.
  - DRAIN→IDLE otherwise, with done.
- Stale buffer contents from a previous iteration are covered by FILL suppression. No buffer reset is needed between iterations.
- iterations == 0: no transfers; done pulses the cycle after start; busy stays low.
- start while busy: ignored, no state change.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, pend 0.
- busy rises the cycle after accepted start.
- The first m_axis_power_valid comes one cycle after the (DEPTH+1)-th shift.
- Throughput is one sample/cycle with continuous valid/ready.
- done pulses the cycle after the final last handshake; busy falls in the same cycle.
- Reset asserted in any state: next cycle IDLE, all outputs 0, command abandoned. No done is issued.
- Combinational paths: m_axis_power_ready → s_axis_power_ready, buf_in_valid and buf_shift_ready. No combinational path from s_axis_power_valid to m_axis_power_valid.

## Test plan
All scenarios use COLS=4, ROWS=2, DEPTH=4 (N=8).
- Reset: hold axi_reset 3 cycles with random inputs → every output 0, state IDLE.
- Single iteration, always valid/ready, inputs 1..8:
  - m_axis_power_data = 1..8 in order, valid first one cycle after the 5th accepted input.
  - last with 8; 4 zero shifts in FLUSH; done one cycle after.
- Backpressure: drop m_axis_power_ready for 3 cycles while pend=1 →
  - s_axis_power_ready and buf_in_valid low;
  - tail value held;
  - no loss or duplication; sequence still 1..8.
- iterations=3, inputs 1..8 per pass → 24 outputs, last on each 8th, iter_count 0→1→2, exactly one done.
- iterations=0 → done one cycle after start, s_axis_power_ready never high; a start pulse while busy in another run is ignored.
- Reset mid-RUN (after 6 inputs):
  - next cycle IDLE, outputs 0, no done;
  - a fresh start then yields 1..8 correctly.
